// File: rtl/tri_bbox_scanner_pkg.sv
// Shared types for the triangle bbox scanner: vertex/triangle layout, pixel request and frame size.
// Vertex i of a tri_2d occupies bits [i*32 +: 32], with x in the upper half.
package tri_bbox_scanner_pkg;

  localparam int FRAME_WIDTH  = 512;
  localparam int FRAME_HEIGHT = 384;
  localparam int COORD_W      = 16;
  localparam int COLOR_W      = 16;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
  } vec2_i16;

  typedef vec2_i16 [2:0] tri_2d;

  typedef struct packed {
    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    tri_2d              tri2d;
    logic [COLOR_W-1:0] col;
    logic               last;
  } pix_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BBOX,
    ST_SCAN
  } scan_state_t;

endpackage

// File: rtl/tri_bbox_clamp.sv
// Combinational bounding box of a triangle, clamped to the frame.
// empty is set when the clamped box has no pixels (triangle fully off-screen).
module tri_bbox_clamp #(
  parameter int FRAME_WIDTH  = tri_bbox_scanner_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT = tri_bbox_scanner_pkg::FRAME_HEIGHT
) (
  input  tri_bbox_scanner_pkg::tri_2d                     tri_v,
  output logic [tri_bbox_scanner_pkg::COORD_W-1:0]        xmin,
  output logic [tri_bbox_scanner_pkg::COORD_W-1:0]        xmax,
  output logic [tri_bbox_scanner_pkg::COORD_W-1:0]        ymin,
  output logic [tri_bbox_scanner_pkg::COORD_W-1:0]        ymax,
  output logic                                            empty
);
  import tri_bbox_scanner_pkg::*;

  localparam logic signed [COORD_W-1:0] X_HI = COORD_W'(FRAME_WIDTH - 1);
  localparam logic signed [COORD_W-1:0] Y_HI = COORD_W'(FRAME_HEIGHT - 1);

  logic signed [COORD_W-1:0] vx [3];
  logic signed [COORD_W-1:0] vy [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_vert
      assign vx[gi] = tri_v[gi].x;
      assign vy[gi] = tri_v[gi].y;
    end
  endgenerate

  function automatic logic signed [COORD_W-1:0] smin3(
    input logic signed [COORD_W-1:0] a, b, c);
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [COORD_W-1:0] smax3(
    input logic signed [COORD_W-1:0] a, b, c);
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  logic signed [COORD_W-1:0] min_x, max_x, min_y, max_y;
  logic signed [COORD_W-1:0] xmin_s, xmax_s, ymin_s, ymax_s;

  assign min_x = smin3(vx[0], vx[1], vx[2]);
  assign max_x = smax3(vx[0], vx[1], vx[2]);
  assign min_y = smin3(vy[0], vy[1], vy[2]);
  assign max_y = smax3(vy[0], vy[1], vy[2]);

  assign xmin_s = (min_x < 0)    ? '0   : min_x;
  assign xmax_s = (max_x > X_HI) ? X_HI : max_x;
  assign ymin_s = (min_y < 0)    ? '0   : min_y;
  assign ymax_s = (max_y > Y_HI) ? Y_HI : max_y;

  // Signed compare so a box lying entirely left of / above the frame is also empty.
  assign empty = (xmin_s > xmax_s) || (ymin_s > ymax_s);

  assign xmin = xmin_s;
  assign xmax = xmax_s;
  assign ymin = ymin_s;
  assign ymax = ymax_s;

endmodule

// File: rtl/tri_bbox_scanner.sv
// Per-triangle raster scanner: accepts a triangle, clamps its bbox, emits box pixels in raster order.
// Optional TRI_BBOX_SCANNER_STATS_EN adds saturating triangle/cull/pixel counters.
module tri_bbox_scanner #(
  parameter int FRAME_WIDTH  = tri_bbox_scanner_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT = tri_bbox_scanner_pkg::FRAME_HEIGHT,
  parameter int COORD_BITS   = 16,
  parameter int COLOR_BITS   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tri_valid,
  output logic                    tri_ready,
  input  logic [6*COORD_BITS-1:0] tri_in,
  input  logic [COLOR_BITS-1:0]   col_in,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [COORD_BITS-1:0]   pix_hcount,
  output logic [COORD_BITS-1:0]   pix_vcount,
  output logic [6*COORD_BITS-1:0] pix_tri,
  output logic [COLOR_BITS-1:0]   pix_col,
  output logic                    pix_last,
  output logic                    busy
`ifdef TRI_BBOX_SCANNER_STATS_EN
  ,
  output logic [31:0]             stat_tris,
  output logic [31:0]             stat_culled,
  output logic [31:0]             stat_pixels
`endif
);
  import tri_bbox_scanner_pkg::*;

  scan_state_t        state_reg;
  logic               tri_ready_reg;
  logic               busy_reg;
  logic               pix_valid_reg;
  pix_req_t           pix_reg;
  logic [COORD_W-1:0] xmin_reg, xmax_reg, ymax_reg;

  logic [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic               bb_empty;

  // The latched triangle is stable through BBOX, so the clamp reads it directly.
  tri_bbox_clamp #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT)
  ) u_clamp (
    .tri_v(pix_reg.tri2d),
    .xmin (bb_xmin),
    .xmax (bb_xmax),
    .ymin (bb_ymin),
    .ymax (bb_ymax),
    .empty(bb_empty)
  );

  logic               tri_accept, pix_fire, x_wrap, last_next;
  logic [COORD_W-1:0] x_next, y_next;

  assign tri_accept = tri_valid && tri_ready_reg;
  assign pix_fire   = pix_valid_reg && pix_ready;
  assign x_wrap     = (pix_reg.hcount == xmax_reg);
  assign x_next     = x_wrap ? xmin_reg : pix_reg.hcount + 16'd1;
  assign y_next     = x_wrap ? pix_reg.vcount + 16'd1 : pix_reg.vcount;
  assign last_next  = (x_next == xmax_reg) && (y_next == ymax_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      tri_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      pix_valid_reg <= 1'b0;
      pix_reg       <= '0;
      xmin_reg      <= '0;
      xmax_reg      <= '0;
      ymax_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (tri_accept) begin
            pix_reg.tri2d <= tri_in;
            pix_reg.col   <= col_in;
            tri_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_BBOX;
          end
        end
        ST_BBOX: begin
          if (bb_empty) begin
            tri_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end else begin
            pix_reg.hcount <= bb_xmin;
            pix_reg.vcount <= bb_ymin;
            pix_reg.last   <= (bb_xmin == bb_xmax) && (bb_ymin == bb_ymax);
            xmin_reg       <= bb_xmin;
            xmax_reg       <= bb_xmax;
            ymax_reg       <= bb_ymax;
            pix_valid_reg  <= 1'b1;
            state_reg      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (pix_fire) begin
            if (pix_reg.last) begin
              pix_valid_reg <= 1'b0;
              pix_reg.last  <= 1'b0;
              tri_ready_reg <= 1'b1;
              busy_reg      <= 1'b0;
              state_reg     <= ST_IDLE;
            end else begin
              pix_reg.hcount <= x_next;
              pix_reg.vcount <= y_next;
              pix_reg.last   <= last_next;
            end
          end
        end
        default: begin
          pix_valid_reg <= 1'b0;
          tri_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign tri_ready  = tri_ready_reg;
  assign busy       = busy_reg;
  assign pix_valid  = pix_valid_reg;
  assign pix_hcount = pix_reg.hcount;
  assign pix_vcount = pix_reg.vcount;
  assign pix_tri    = pix_reg.tri2d;
  assign pix_col    = pix_reg.col;
  assign pix_last   = pix_reg.last;

`ifdef TRI_BBOX_SCANNER_STATS_EN
  logic [31:0] stat_tris_reg, stat_culled_reg, stat_pixels_reg;
  logic        cull_evt;

  assign cull_evt = (state_reg == ST_BBOX) && bb_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_tris_reg   <= '0;
      stat_culled_reg <= '0;
      stat_pixels_reg <= '0;
    end else begin
      if (tri_accept && (state_reg == ST_IDLE) && (stat_tris_reg != '1))
        stat_tris_reg <= stat_tris_reg + 32'd1;
      if (cull_evt && (stat_culled_reg != '1))
        stat_culled_reg <= stat_culled_reg + 32'd1;
      if (pix_fire && (stat_pixels_reg != '1))
        stat_pixels_reg <= stat_pixels_reg + 32'd1;
    end
  end

  assign stat_tris   = stat_tris_reg;
  assign stat_culled = stat_culled_reg;
  assign stat_pixels = stat_pixels_reg;
`endif

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Scoreboard bench for tri_bbox_scanner: stimulus pushes expected pixels, a negedge monitor pops on handshake.
module tb_tri_bbox_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tri_valid = 1'b0;
  logic        tri_ready;
  logic [95:0] tri_in = '0;
  logic [15:0] col_in = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [15:0] pix_hcount, pix_vcount;
  logic [95:0] pix_tri;
  logic [15:0] pix_col;
  logic        pix_last;
  logic        busy;
`ifdef TRI_BBOX_SCANNER_STATS_EN
  logic [31:0] stat_tris, stat_culled, stat_pixels;
`endif

  tri_bbox_scanner dut (
    .clk       (clk),
    .rst       (rst),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .tri_in    (tri_in),
    .col_in    (col_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_hcount(pix_hcount),
    .pix_vcount(pix_vcount),
    .pix_tri   (pix_tri),
    .pix_col   (pix_col),
    .pix_last  (pix_last),
    .busy      (busy)
`ifdef TRI_BBOX_SCANNER_STATS_EN
    ,
    .stat_tris  (stat_tris),
    .stat_culled(stat_culled),
    .stat_pixels(stat_pixels)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  int          n_acc = 0;
  int          n_cull = 0;
  int          n_hs = 0;
  logic [95:0] exp_tri = '0;
  logic [15:0] exp_col = '0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [95:0] pack(input int x0, y0, x1, y1, x2, y2);
    return {16'(x2), 16'(y2), 16'(x1), 16'(y1), 16'(x0), 16'(y0)};
  endfunction

  // Expected raster order over a hand-derived box; limit truncates long scans.
  task automatic push_box(input int x0, x1, y0, y1, input int limit);
    int   n;
    exp_t en;
    n = 0;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        if (n < limit) begin
          en.x    = 16'(x);
          en.y    = 16'(y);
          en.last = (x == x1) && (y == y1);
          q.push_back(en);
          n++;
        end
  endtask

  // Monitor: hold check during stalls, scoreboard pop on every handshake.
  logic        stall_prev = 1'b0;
  logic [15:0] sx, sy;
  logic        sl;
  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev) begin
        check("hold_valid", pix_valid, 1);
        check("hold_x", pix_hcount, sx);
        check("hold_y", pix_vcount, sy);
        check("hold_last", pix_last, sl);
      end
      if (pix_valid && pix_ready) begin
        n_hs++;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pixel: got (%0d,%0d) last=%0b, required no pixel",
                   pix_hcount, pix_vcount, pix_last);
        end else begin
          e = q.pop_front();
          $display("[TB] pixel (%0d,%0d) last=%0b", pix_hcount, pix_vcount, pix_last);
          check("pix_x", pix_hcount, e.x);
          check("pix_y", pix_vcount, e.y);
          check("pix_last", pix_last, e.last);
          check("pix_tri", pix_tri, exp_tri);
          check("pix_col", pix_col, exp_col);
        end
      end
      stall_prev = pix_valid && !pix_ready;
      sx = pix_hcount;
      sy = pix_vcount;
      sl = pix_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Issue one triangle; returns at the negedge of cycle N+2 after the accept cycle N.
  task automatic send(input logic [95:0] t, input logic [15:0] c, input bit culled, input string tag);
    @(posedge clk);
    #1;
    tri_in    = t;
    col_in    = c;
    tri_valid = 1'b1;
    exp_tri   = t;
    exp_col   = c;
    @(negedge clk);
    check({tag, "_ready_idle"}, tri_ready, 1);
    @(posedge clk);
    #1;
    tri_valid = 1'b0;
    tri_in    = ~t;
    col_in    = ~c;
    n_acc++;
    if (culled) n_cull++;
    @(negedge clk);
    check({tag, "_busy_n1"}, busy, 1);
    check({tag, "_ready_n1"}, tri_ready, 0);
    check({tag, "_valid_n1"}, pix_valid, 0);
    @(negedge clk);
    check({tag, "_valid_n2"}, pix_valid, !culled);
    check({tag, "_busy_n2"}, busy, !culled);
    check({tag, "_ready_n2"}, tri_ready, culled);
    $display("[TB] triangle %s accepted, culled=%0b", tag, culled);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i;
    i = 0;
    while (q.size() != 0 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d pixels outstanding after %0d cycles, required 0", tag, q.size(), budget);
      q.delete();
    end
  endtask

  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #1 rst = 1'b0;
    #1;
    check("rst_tri_ready", tri_ready, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pix_last", pix_last, 0);
    check("rst_pix_hcount", pix_hcount, 0);
    check("rst_pix_tri", pix_tri, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Small in-frame box (2..5, 3..4)
    pix_ready = 1'b1;
    push_box(2, 5, 3, 4, 1000);
    send(pack(2, 3, 5, 3, 2, 4), 16'hF800, 1'b0, "t1");
    wait_drain("t1", 50);
    @(negedge clk);
    check("t1_ready_after", tri_ready, 1);
    check("t1_busy_after", busy, 0);
    check("t1_valid_after", pix_valid, 0);

    // Bottom-right clamp: box (505..511, 378..383)
    push_box(505, 511, 378, 383, 1000);
    send(pack(505, 378, 530, 379, 508, 400), 16'h07E0, 1'b0, "t2");
    wait_drain("t2", 100);

    // Top-left clamp from negative vertices: box (0..1, 0..1)
    push_box(0, 1, 0, 1, 1000);
    send(pack(-3, -2, 1, -9, 0, 1), 16'h001F, 1'b0, "t3");
    wait_drain("t3", 50);

    // Fully off-screen to the right
    send(pack(600, 10, 700, 20, 650, 30), 16'h5555, 1'b1, "cull");
    repeat (3) @(negedge clk);
    check("cull_valid_later", pix_valid, 0);

    // Degenerate single pixel
    push_box(7, 7, 7, 7, 1000);
    send(pack(7, 7, 7, 7, 7, 7), 16'h1234, 1'b0, "single");
    check("single_last_with_valid", pix_last, 1);
    wait_drain("single", 20);

    // 3x1 box under backpressure
    pix_ready = 1'b0;
    push_box(10, 12, 20, 20, 1000);
    send(pack(10, 20, 12, 20, 11, 20), 16'hABCD, 1'b0, "stall");
    foreach (pat[i]) begin
      @(posedge clk);
      #1 pix_ready = pat[i];
    end
    pix_ready = 1'b1;
    wait_drain("stall", 20);
    @(negedge clk);
`ifdef TRI_BBOX_SCANNER_STATS_EN
    check("stat_tris", stat_tris, 32'(n_acc));
    check("stat_culled", stat_culled, 32'(n_cull));
    check("stat_pixels", stat_pixels, 32'(n_hs));
`endif

    // Full-frame clamp, aborted by reset after the first 600 pixels
    push_box(0, 511, 0, 383, 600);
    send(pack(-10, -10, 600, -5, 0, 500), 16'hFFFF, 1'b0, "full");
    wait_drain("full", 1000);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_pix_valid", pix_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_tri_ready", tri_ready, 1);
    check("abort_pix_hcount", pix_hcount, 0);
`ifdef TRI_BBOX_SCANNER_STATS_EN
    check("abort_stat_tris", stat_tris, 0);
    check("abort_stat_culled", stat_culled, 0);
    check("abort_stat_pixels", stat_pixels, 0);
`endif
    @(negedge clk);
    #2 rst = 1'b1;

    push_box(7, 7, 7, 7, 1000);
    send(pack(7, 7, 7, 7, 7, 7), 16'h4321, 1'b0, "post_rst");
    wait_drain("post_rst", 20);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
